// File: rtl/i2c_slave_if.sv
// i2c_slave user-side bundle: transmit byte in, received byte and status out.
// The I2C pins themselves stay as plain ports on the responder.
interface i2c_slave_if;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic [3:0] state;

    modport slave (
        input  tx_data,
        output tx_load, rx_data, rx_valid, busy, state
    );

    modport master (
        output tx_data,
        input  tx_load, rx_data, rx_valid, busy, state
    );
endinterface

// File: rtl/i2c_slave.sv
// i2c_slave: oversampled 7-bit-address I2C responder.
// Open-drain sda, byte read/write with ACK handling and repeated START.
module i2c_slave #(
    parameter logic [6:0] i2c_slave_address = 7'h01
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    inout  wire  sda,
    i2c_slave_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        WRITE     = 4'd3,
        WRITE_ACK = 4'd4,
        READ      = 4'd5,
        READ_ACK  = 4'd6,
        WAIT_STOP = 4'd7
    } state_t;

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;
    logic scl_rise, scl_fall, start_c, stop_c;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic       done_q, done_d;
    logic       rw_q, rw_d;
    logic       low_q, low_d;
    logic       busy_q, busy_d;
    logic       pend_q, pend_d;
    logic       rxv_q, rxv_d;
    logic       load_q, load_d;

    // Two-flop synchronizer plus one delay flop; idle bus level is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise = scl_s2 & ~scl_d;
    assign scl_fall = ~scl_s2 & scl_d;
    assign start_c  = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_c   = scl_s2 & scl_d & ~sda_d & sda_s2;

    // Next-state and datapath decisions; STOP outranks START.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        done_d  = done_q;
        rw_d    = rw_q;
        low_d   = low_q;
        busy_d  = busy_q;
        pend_d  = 1'b0;
        rxv_d   = pend_q;
        load_d  = 1'b0;
        if (stop_c) begin
            state_d = IDLE;
            low_d   = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = 3'd0;
            done_d  = 1'b0;
        end else if (start_c) begin
            state_d = ADDR;
            low_d   = 1'b0;
            cnt_d   = 3'd0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                ADDR, WRITE: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s2};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            done_d = 1'b1;
                            if (state_q == WRITE) begin
                                rx_d   = {shift_q[6:0], sda_s2};
                                pend_d = 1'b1;
                            end
                        end
                    end else if (scl_fall && done_q) begin
                        done_d = 1'b0;
                        if (state_q == WRITE) begin
                            low_d   = 1'b1;
                            state_d = WRITE_ACK;
                        end else if (shift_q[7:1] == i2c_slave_address) begin
                            low_d   = 1'b1;
                            busy_d  = 1'b1;
                            rw_d    = shift_q[0];
                            state_d = ADDR_ACK;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        low_d  = 1'b0;
                        cnt_d  = 3'd0;
                        done_d = 1'b0;
                        if (rw_q) begin
                            state_d = READ;
                            tx_d    = bus.tx_data;
                            load_d  = 1'b1;
                            low_d   = ~bus.tx_data[7];
                        end else begin
                            state_d = WRITE;
                        end
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        low_d   = 1'b0;
                        state_d = WRITE;
                    end
                end
                READ: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            low_d   = 1'b0;
                            cnt_d   = 3'd0;
                            done_d  = 1'b0;
                            state_d = READ_ACK;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                            tx_d  = tx_q << 1;
                            low_d = ~tx_q[6];
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_s2) state_d = WAIT_STOP;
                        else        done_d  = 1'b1;
                    end else if (scl_fall && done_q) begin
                        done_d  = 1'b0;
                        tx_d    = bus.tx_data;
                        load_d  = 1'b1;
                        low_d   = ~bus.tx_data[7];
                        state_d = READ;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and datapath registers; reset releases sda at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            done_q  <= 1'b0;
            rw_q    <= 1'b0;
            low_q   <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
            rxv_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            done_q  <= done_d;
            rw_q    <= rw_d;
            low_q   <= low_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            rxv_q   <= rxv_d;
            load_q  <= load_d;
        end
    end

    assign sda          = low_q ? 1'b0 : 1'bz;
    assign bus.tx_load  = load_q;
    assign bus.rx_data  = rx_q;
    assign bus.rx_valid = rxv_q;
    assign bus.busy     = busy_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master with a transaction-level model.
// Expected bytes go into queues; a monitor pops them on DUT pulses.
module tb_i2c_slave;

    localparam int Q = 8;
    localparam logic [6:0] SLV = 7'h01;

    logic clk = 1'b0;
    logic rst;
    logic scl;
    logic m_low;
    wire  sda;

    i2c_slave_if bus ();

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave #(.i2c_slave_address(SLV)) dut (
        .clk(clk),
        .rst(rst),
        .scl(scl),
        .sda(sda),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int loads = 0;
    int rxv_cnt = 0;
    bit m_busy = 1'b0;
    logic [7:0] dat [4];
    logic [7:0] exp_rx [$];
    logic [7:0] exp_rd [$];
    logic [7:0] obs_rd [$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare every DUT-presented byte against the model queues.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rx_valid === 1'b1) begin
                rxv_cnt++;
                if (exp_rx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_unexpected: got %0h want none",
                             bus.rx_data);
                end else begin
                    check("rx_data", bus.rx_data, exp_rx.pop_front());
                end
            end
            if (bus.tx_load === 1'b1) loads++;
            if (obs_rd.size() > 0) begin
                if (exp_rd.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected: got %0h want none",
                             obs_rd.pop_front());
                end else begin
                    check("rd_byte", obs_rd.pop_front(), exp_rd.pop_front());
                end
            end
        end
    end

    task automatic wt(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m_start();
        m_low = 1'b0;
        wt(Q);
        scl = 1'b1;
        wt(Q);
        m_low = 1'b1;
        wt(Q);
        scl = 1'b0;
    endtask

    task automatic m_stop();
        wt(Q);
        m_low = 1'b1;
        wt(Q);
        scl = 1'b1;
        wt(Q);
        m_low = 1'b0;
        wt(2 * Q);
    endtask

    task automatic m_bit(input bit b, output bit s);
        wt(Q);
        m_low = ~b;
        wt(Q);
        scl = 1'b1;
        wt(Q);
        @(negedge clk);
        s = (sda !== 1'b0);
        wt(Q);
        scl = 1'b0;
    endtask

    task automatic m_wbyte(input logic [7:0] d, output bit ack);
        bit s;
        for (int i = 7; i >= 0; i--) m_bit(d[i], s);
        m_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic xfer(input logic [6:0] a, input bit rw, input int n);
        bit ok, s, hit;
        logic [7:0] d;
        int l0;
        hit = (a == SLV);
        l0 = loads;
        if (rw) begin
            bus.tx_data = dat[0];
            if (hit) exp_rd.push_back(dat[0]);
        end
        m_start();
        m_wbyte({a, rw}, ok);
        check("addr_ack", ok, hit);
        if (hit) m_busy = 1'b1;
        check("busy_after_addr", bus.busy, m_busy);
        if (!hit) begin
            check("miss_state", bus.state, 7);
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (!rw) begin
                exp_rx.push_back(dat[k]);
                m_wbyte(dat[k], ok);
                check("data_ack", ok, 1);
            end else begin
                for (int i = 7; i >= 0; i--) begin
                    m_bit(1'b1, s);
                    d[i] = s;
                end
                obs_rd.push_back(d);
                if (k < n - 1) begin
                    bus.tx_data = dat[k + 1];
                    exp_rd.push_back(dat[k + 1]);
                    m_bit(1'b0, s);
                end else begin
                    m_bit(1'b1, s);
                    wt(4);
                    check("nack_state", bus.state, 7);
                end
            end
        end
        if (rw) check("tx_loads", loads - l0, n);
    endtask

    task automatic do_stop();
        m_stop();
        m_busy = 1'b0;
        check("stop_state", bus.state, 0);
        check("stop_busy", bus.busy, 0);
        check("rx_drain", exp_rx.size(), 0);
        check("rd_drain", exp_rd.size(), 0);
    endtask

    initial begin
        bit ok, s, hit, rw;
        int r0, n;
        logic [6:0] a;

        rst = 1'b0;
        scl = 1'b1;
        m_low = 1'b0;
        bus.tx_data = 8'h00;
        wt(4);
        check("rst_state", bus.state, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_tx_load", bus.tx_load, 0);
        check("rst_sda", sda !== 1'b0, 1);
        rst = 1'b1;
        wt(4);

        // Write 0xA5 to our address.
        r0 = rxv_cnt;
        dat[0] = 8'hA5;
        xfer(SLV, 1'b0, 1);
        do_stop();
        check("wr_rx_data", bus.rx_data, 8'hA5);
        check("wr_rx_pulses", rxv_cnt - r0, 1);

        // Read 0x3C, master NACK.
        dat[0] = 8'h3C;
        xfer(SLV, 1'b1, 1);
        do_stop();

        // Foreign address: never ACKs anything.
        xfer(7'h02, 1'b0, 1);
        m_wbyte(8'hC3, ok);
        check("miss_data_ack", ok, 0);
        check("miss_busy", bus.busy, 0);
        do_stop();

        // Write, repeated START, two-byte read.
        dat[0] = 8'h11;
        xfer(SLV, 1'b0, 1);
        dat[0] = 8'hF0;
        dat[1] = 8'h5A;
        xfer(SLV, 1'b1, 2);
        do_stop();
        check("rs_rx_data", bus.rx_data, 8'h11);

        // Reset in the middle of a read of 0x00.
        bus.tx_data = 8'h00;
        m_start();
        m_wbyte({SLV, 1'b1}, ok);
        check("rstx_addr_ack", ok, 1);
        for (int i = 0; i < 4; i++) m_bit(1'b1, s);
        wt(Q);
        check("rstx_bit5_low", sda !== 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstx_sda_rel", sda !== 1'b0, 1);
        check("rstx_state", bus.state, 0);
        check("rstx_busy", bus.busy, 0);
        wt(2);
        rst = 1'b1;
        m_busy = 1'b0;
        wt(Q);
        scl = 1'b1;
        wt(2 * Q);
        check("rstx_idle", bus.state, 0);
        dat[0] = 8'h6E;
        xfer(SLV, 1'b0, 1);
        do_stop();
        check("rstx_wr", bus.rx_data, 8'h6E);

        // STOP after half a byte: no rx_valid.
        m_start();
        m_wbyte({SLV, 1'b0}, ok);
        check("part_addr_ack", ok, 1);
        m_busy = 1'b1;
        for (int i = 0; i < 4; i++) m_bit(1'($urandom_range(0, 1)), s);
        r0 = rxv_cnt;
        do_stop();
        check("part_no_rxv", rxv_cnt - r0, 0);
        check("part_rx_keep", bus.rx_data, 8'h6E);

        // Random transactions.
        for (int t = 0; t < 16; t++) begin
            hit = 1'($urandom_range(0, 1));
            a = hit ? SLV : 7'($urandom_range(2, 127));
            rw = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) dat[k] = 8'($urandom);
            xfer(a, rw, n);
            do_stop();
        end

        wt(4);
        check("end_obs_drain", obs_rd.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL provide parameter: i2c_slave_address, 7'h01, 7-bit address this responder answers.
REQ-002 SHALL provide ports, one clock; reset is asynchronous and active-low:
- clk  input  1  internal clock; all logic on posedge, oversamples the I2C bus.
- rst  input  1  asynchronous, active-low reset.
- scl  input  1  serial clock from the master.
- sda  inout  1  serial data; open-drain, driven 1'b0 or 1'bz only.
- tx_data  input  8  byte returned to the master on reads.
- tx_load  output  1  one-clk pulse when tx_data is latched into the shifter.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- busy  output  1  high from address match until STOP.
- state  output  4  current FSM state.

Function
REQ-003 SHALL pass scl and sda through a 2-flop synchronizer, plus one delay flop for edge detection.
- An edge is detected 3 clk after the pin changes.
REQ-004 SHALL detect bus conditions from the synchronized signals:
- START: sda falls while scl is high.
- STOP: sda rises while scl is high.
- scl rise: the sample point.
- scl fall: the drive-change point.
REQ-005 SHALL implement these states and encodings:
- IDLE=0, ADDR=1, ADDR_ACK=2, WRITE=3, WRITE_ACK=4, READ=5, READ_ACK=6, WAIT_STOP=7.
REQ-006 In ADDR, SHALL shift 8 bits MSB-first on scl rises: 7 address bits, then the R/W bit.
- R/W = 1 means the master reads; R/W = 0 means the master writes.
REQ-007 On the scl fall after the 8th address bit:
- if the address matches, SHALL drive sda low and enter ADDR_ACK;
- on a mismatch, SHALL enter WAIT_STOP and leave sda released.
REQ-008 On the scl fall ending the ACK bit, SHALL release sda and enter WRITE (R/W=0) or READ (R/W=1).
REQ-009 On the transition into READ:
- SHALL latch tx_data and pulse tx_load in the same clk;
- SHALL drive the MSB immediately (0 means sda low, 1 means sda released).
REQ-010 In WRITE, SHALL shift 8 bits MSB-first on scl rises.
- On the 8th rise, SHALL update rx_data and pulse rx_valid one clk later.
- On the following scl fall, SHALL drive the ACK low and enter WRITE_ACK.
REQ-011 WRITE_ACK SHALL release sda on the next scl fall and return to WRITE for the next byte.
REQ-012 In READ, SHALL present the next bit on each scl fall.
- After the 8th bit, SHALL release sda on the scl fall and enter READ_ACK.
REQ-013 In READ_ACK, SHALL sample sda on the scl rise:
- 0 (ACK): on the next scl fall, reload tx_data, pulse tx_load, drive the MSB, and enter READ.
- 1 (NACK): keep sda released and enter WAIT_STOP.
REQ-014 A START detected in any state (repeated start) SHALL:
- release sda;
- clear the bit counter;
- enter ADDR.
REQ-015 A STOP detected in any state SHALL release sda, deassert busy and enter IDLE.
- A STOP with a partial byte SHALL NOT pulse rx_valid.
REQ-016 SHALL drive sda low only in these cases:
- ADDR_ACK;
- WRITE_ACK;
- READ data-0 bits.
REQ-017 A simultaneous START and STOP SHALL never occur; if glitching produces both in one clk, STOP SHALL take priority.
REQ-018 busy SHALL rise on the address-match ACK and fall on STOP.
REQ-019 The bit counter SHALL be 3 bits, SHALL wrap from 7 to 0 at each byte boundary, and SHALL never overflow into the ACK bit.

Reset
REQ-020 While rst=0, asynchronously and regardless of clk, SHALL apply:
- state=IDLE;
- sda released (z);
- rx_data=8'h00;
- rx_valid=0, tx_load=0, busy=0;
- counters and shifters cleared.
REQ-021 Reset asserted mid-transfer SHALL release sda within the same clk.
REQ-022 After rst deasserts, the block SHALL ignore bus activity until the next START.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Write, address 0x01, data 0xA5, STOP -> ACK low on bits 9 and 18; rx_data=0xA5; one rx_valid pulse; busy 1 then 0.
- Read, address 0x01, tx_data=0x3C, master NACK -> bits 0,0,1,1,1,1,0,0 on sda; tx_load pulses once; WAIT_STOP then IDLE.
- Address 0x02 -> sda never driven; busy stays 0; state goes through WAIT_STOP to IDLE on STOP.
- Write 0x11, then repeated START with a read of 0x01, tx_data=0xF0, master ACK then NACK -> rx_data=0x11; two tx_load pulses; second byte reflects the updated tx_data.
- rst=0 asserted during the 5th READ bit of data 0x00 -> sda goes z immediately and state=0; the next full write transaction succeeds.
- STOP after 4 bits of a write byte -> no rx_valid; state=IDLE.
